// File: rtl/wrapper_packet_arbiter.sv
// Round-robin, block-granular arbiter sharing one registered packet output between NUM_SRC sources.
// Optional starvation guard enabled by defining WRAPPER_PACKET_ARB_STARVE_GUARD_EN.
module wrapper_packet_arbiter #(
    parameter int unsigned NUM_SRC          = 4,
    parameter int unsigned PACKETWIDTH      = 256,
    parameter int unsigned PACKETSPACEWIDTH = 6,
    localparam int unsigned SELW            = $clog2(NUM_SRC)
) (
    input  logic                                      hclk,
    input  logic                                      hreset,
    input  logic [NUM_SRC-1:0][PACKETWIDTH-1:0]       src_data,
    input  logic [NUM_SRC-1:0]                        src_last,
    input  logic [NUM_SRC-1:0][PACKETSPACEWIDTH-1:0]  src_remain,
    input  logic [NUM_SRC-1:0]                        src_valid,
    output logic [NUM_SRC-1:0]                        src_ready,
    output logic [PACKETWIDTH-1:0]                    packet_data,
    output logic                                      packet_data_last,
    output logic [PACKETSPACEWIDTH-1:0]               packet_data_remain,
    output logic                                      packet_data_valid,
    input  logic                                      packet_data_ready,
    output logic                                      grant_active,
    output logic [SELW-1:0]                           grant_id,
    output logic                                      block_err,
    input  logic                                      err_clear
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                      state_q;
    logic [SELW-1:0]             rr_ptr_q;
    logic [SELW-1:0]             grant_id_q;
    logic                        grant_active_q;
    logic [PACKETWIDTH-1:0]      pd_data_q;
    logic                        pd_last_q;
    logic [PACKETSPACEWIDTH-1:0] pd_remain_q;
    logic                        pd_valid_q;
    logic [PACKETSPACEWIDTH-1:0] exp_remain_q;
    logic                        first_beat_q;
    logic                        block_err_q;

    logic                        any_valid;
    logic                        rr_found;
    logic [SELW-1:0]             rr_idx;
    logic [SELW-1:0]             rr_pick;
    logic [SELW-1:0]             grant_pick;
    logic [SELW-1:0]             rr_ptr_d;
    logic                        xfer;
    logic                        frame_err;
    logic [PACKETWIDTH-1:0]      sel_data;
    logic                        sel_last;
    logic [PACKETSPACEWIDTH-1:0] sel_remain;

    assign any_valid  = |src_valid;
    assign sel_data   = src_data[grant_id_q];
    assign sel_last   = src_last[grant_id_q];
    assign sel_remain = src_remain[grant_id_q];
    assign rr_ptr_d   = (grant_id_q == SELW'(NUM_SRC - 1)) ? '0 : grant_id_q + SELW'(1);

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rr_idx = SELW'((32'(rr_ptr_q) + i) % NUM_SRC);
            if (!rr_found && src_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

`ifdef WRAPPER_PACKET_ARB_STARVE_GUARD_EN
    logic [NUM_SRC-1:0][7:0] wait_q;
    logic                    starve_found;
    logic [SELW-1:0]         starve_pick;

    always_comb begin
        starve_found = 1'b0;
        starve_pick  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!starve_found && src_valid[i] && wait_q[i] == 8'hFF) begin
                starve_found = 1'b1;
                starve_pick  = SELW'(i);
            end
        end
    end

    assign grant_pick = starve_found ? starve_pick : rr_pick;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wait_q <= '0;
        end else if (state_q == StIdle && any_valid) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (SELW'(i) == grant_pick) begin
                    wait_q[i] <= '0;
                end else if (src_valid[i] && wait_q[i] != 8'hFF) begin
                    wait_q[i] <= wait_q[i] + 8'd1;
                end
            end
        end
    end
`else
    assign grant_pick = rr_pick;
`endif

    always_comb begin
        src_ready = '0;
        if (state_q == StLocked) begin
            src_ready[grant_id_q] = !pd_valid_q || packet_data_ready;
        end
    end

    assign xfer = (state_q == StLocked) && src_valid[grant_id_q] && src_ready[grant_id_q];

    // Remain must count down by one per beat and hit zero exactly on the last beat.
    always_comb begin
        frame_err = 1'b0;
        if (sel_last && sel_remain != '0) begin
            frame_err = 1'b1;
        end
        if (!sel_last && sel_remain == '0) begin
            frame_err = 1'b1;
        end
        if (!first_beat_q &&
            (exp_remain_q == '0 || sel_remain != exp_remain_q - PACKETSPACEWIDTH'(1))) begin
            frame_err = 1'b1;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            pd_data_q      <= '0;
            pd_last_q      <= 1'b0;
            pd_remain_q    <= '0;
            pd_valid_q     <= 1'b0;
            exp_remain_q   <= '0;
            first_beat_q   <= 1'b1;
            block_err_q    <= 1'b0;
        end else begin
            block_err_q <= (xfer && frame_err) || (block_err_q && !err_clear);

            if (xfer) begin
                pd_data_q    <= sel_data;
                pd_last_q    <= sel_last;
                pd_remain_q  <= sel_remain;
                pd_valid_q   <= 1'b1;
                exp_remain_q <= sel_remain;
                first_beat_q <= sel_last;
            end else if (packet_data_ready) begin
                pd_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        grant_id_q     <= grant_pick;
                        grant_active_q <= 1'b1;
                        state_q        <= StLocked;
                    end
                end
                StLocked: begin
                    if (xfer && sel_last) begin
                        grant_active_q <= 1'b0;
                        rr_ptr_q       <= rr_ptr_d;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign packet_data        = pd_data_q;
    assign packet_data_last   = pd_last_q;
    assign packet_data_remain = pd_remain_q;
    assign packet_data_valid  = pd_valid_q;
    assign grant_active       = grant_active_q;
    assign grant_id           = grant_id_q;
    assign block_err          = block_err_q;

endmodule

// File: tb/tb_wrapper_packet_arbiter.sv
// Bench for wrapper_packet_arbiter: table of block scenarios checked through an expected-beat
// queue, plus directed latency, framing-error and mid-block reset sequences.
module tb_wrapper_packet_arbiter;

    localparam int NS = 4;
    localparam int PW = 256;
    localparam int RW = 6;
    localparam int MAXB = 300;

    logic                   hclk = 1'b0;
    logic                   hreset;
    logic [NS-1:0][PW-1:0]  src_data;
    logic [NS-1:0]          src_last;
    logic [NS-1:0][RW-1:0]  src_remain;
    logic [NS-1:0]          src_valid;
    logic [NS-1:0]          src_ready;
    logic [PW-1:0]          packet_data;
    logic                   packet_data_last;
    logic [RW-1:0]          packet_data_remain;
    logic                   packet_data_valid;
    logic                   packet_data_ready;
    logic                   grant_active;
    logic [1:0]             grant_id;
    logic                   block_err;
    logic                   err_clear;

    wrapper_packet_arbiter #(
        .NUM_SRC         (NS),
        .PACKETWIDTH     (PW),
        .PACKETSPACEWIDTH(RW)
    ) dut (
        .hclk              (hclk),
        .hreset            (hreset),
        .src_data          (src_data),
        .src_last          (src_last),
        .src_remain        (src_remain),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .packet_data       (packet_data),
        .packet_data_last  (packet_data_last),
        .packet_data_remain(packet_data_remain),
        .packet_data_valid (packet_data_valid),
        .packet_data_ready (packet_data_ready),
        .grant_active      (grant_active),
        .grant_id          (grant_id),
        .block_err         (block_err),
        .err_clear         (err_clear)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
        logic [RW-1:0] remain;
    } beat_t;

    typedef struct {
        logic [3:0] mask;
        int         nblk;
        int         len;
        int         stall;
        int         corrupt;
        logic       exp_err;
    } vec_t;

    beat_t sbeats [NS][MAXB];
    int    scount [NS];
    int    sptr   [NS];
    beat_t expq   [$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    rr_model = 0;
    vec_t  vecs [8];

    task automatic check(input string name, input logic [PW+7:0] act, input logic [PW+7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int s, input logic l, input int rem);
        beat_t b;
        for (int w = 0; w < PW / 32; w++) b.data[w*32 +: 32] = $urandom;
        b.data[PW-1 -: 8] = 8'(s);
        b.last   = l;
        b.remain = RW'(rem);
        return b;
    endfunction

    function automatic beat_t cur_out();
        beat_t b;
        b.data   = packet_data;
        b.last   = packet_data_last;
        b.remain = packet_data_remain;
        return b;
    endfunction

    task automatic clear_srcs();
        for (int s = 0; s < NS; s++) begin
            scount[s] = 0;
            sptr[s]   = 0;
        end
    endtask

    task automatic drive_src();
        for (int s = 0; s < NS; s++) begin
            if (sptr[s] < scount[s]) begin
                {src_data[s], src_last[s], src_remain[s]} = sbeats[s][sptr[s]];
                src_valid[s] = 1'b1;
            end else begin
                src_data[s]   = '0;
                src_last[s]   = 1'b0;
                src_remain[s] = '0;
                src_valid[s]  = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Builds the expected output order from a round-robin model, then streams all pending beats.
    task automatic run_loop(input int stall, input logic exp_err, input string tag);
        int    mp [NS];
        int    rr;
        int    g;
        int    cycles;
        logic  hold;
        logic  pending;
        beat_t prev;
        beat_t e;
        logic [NS-1:0] hs;
        for (int s = 0; s < NS; s++) mp[s] = sptr[s];
        rr = rr_model;
        forever begin
            g = -1;
            for (int k = 0; k < NS; k++) begin
                if (g < 0 && mp[(rr + k) % NS] < scount[(rr + k) % NS]) g = (rr + k) % NS;
            end
            if (g < 0) break;
            forever begin
                expq.push_back(sbeats[g][mp[g]]);
                mp[g]++;
                if (sbeats[g][mp[g]-1].last || mp[g] >= scount[g]) break;
            end
            rr = (g + 1) % NS;
        end
        rr_model = rr;

        cycles = 0;
        hold = 1'b0;
        prev = '0;
        pending = 1'b1;
        while (pending && cycles < 5000) begin
            drive_src();
            packet_data_ready = ($urandom_range(99) >= 32'(stall));
            @(negedge hclk);
            hs = src_valid & src_ready;
            if (packet_data_valid && !packet_data_ready) check({tag, " bp_ready"}, src_ready, '0);
            if (hold) begin
                check({tag, " hold_beat"}, cur_out(), prev);
                check({tag, " hold_valid"}, packet_data_valid, 1);
            end
            hold = packet_data_valid && !packet_data_ready;
            prev = cur_out();
            if (packet_data_valid && packet_data_ready) begin
                if (expq.size() == 0) begin
                    check({tag, " extra_beat"}, 1, 0);
                end else begin
                    e = expq.pop_front();
                    check({tag, " out_beat"}, cur_out(), e);
                end
            end
            step();
            for (int s = 0; s < NS; s++) if (hs[s]) sptr[s]++;
            cycles++;
            pending = (expq.size() > 0);
            for (int s = 0; s < NS; s++) if (sptr[s] < scount[s]) pending = 1'b1;
        end
        if (cycles >= 5000) begin
            check({tag, " timeout"}, 1, 0);
            expq.delete();
        end
        drive_src();
        packet_data_ready = 1'b1;
        check({tag, " end_valid"}, packet_data_valid, 0);
        check({tag, " end_grant"}, grant_active, 0);
        check({tag, " end_err"}, block_err, exp_err);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lo;
        clear_srcs();
        lo = -1;
        for (int s = 0; s < NS; s++) begin
            if (v.mask[s]) begin
                if (lo < 0) lo = s;
                for (int b = 0; b < v.nblk; b++) begin
                    for (int k = 0; k < v.len; k++) begin
                        sbeats[s][scount[s]] = mk_beat(s, k == v.len - 1, v.len - 1 - k);
                        scount[s]++;
                    end
                end
            end
        end
        if (v.corrupt == 1) sbeats[lo][0].remain = RW'(v.len);
        if (v.corrupt == 2) sbeats[lo][0].last = 1'b1;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check($sformatf("v%0d clear", idx), block_err, 0);
        run_loop(v.stall, v.exp_err, $sformatf("v%0d", idx));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0010, 1, 3,  0, 0, 1'b0};
        vecs[1] = '{4'b0101, 2, 2,  0, 0, 1'b0};
        vecs[2] = '{4'b1111, 2, 1,  0, 0, 1'b0};
        vecs[3] = '{4'b1111, 2, 4, 40, 0, 1'b0};
        vecs[4] = '{4'b1001, 3, 8, 70, 0, 1'b0};
        vecs[5] = '{4'b0110, 1, 3, 20, 1, 1'b1};
        vecs[6] = '{4'b1000, 1, 4,  0, 2, 1'b1};
        vecs[7] = '{4'b1111, 1, 64, 30, 0, 1'b0};

        clear_srcs();
        drive_src();
        err_clear = 1'b0;
        packet_data_ready = 1'b0;
        hreset = 1'b1;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        check("rst valid", packet_data_valid, 0);
        check("rst grant_active", grant_active, 0);
        check("rst grant_id", grant_id, 0);
        check("rst err", block_err, 0);
        check("rst ready", src_ready, 0);
        check("rst beat", cur_out(), '0);
        hreset = 1'b0;
        rr_model = 0;

        // Single source: one bubble, then one beat per cycle with one cycle latency.
        step();
        clear_srcs();
        sbeats[1][0] = mk_beat(1, 1'b0, 2);
        sbeats[1][1] = mk_beat(1, 1'b0, 1);
        sbeats[1][2] = mk_beat(1, 1'b1, 0);
        scount[1] = 3;
        packet_data_ready = 1'b1;
        drive_src();
        step();
        check("A grant_active", grant_active, 1);
        check("A grant_id", grant_id, 1);
        check("A ready", src_ready, 4'b0010);
        check("A bubble", packet_data_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("A beat%0d valid", k), packet_data_valid, 1);
            check($sformatf("A beat%0d", k), cur_out(), sbeats[1][k]);
            sptr[1]++;
            drive_src();
        end
        check("A grant_drop", grant_active, 0);
        check("A ready_idle", src_ready, 0);
        step();
        check("A out_idle", packet_data_valid, 0);
        check("A err", block_err, 0);
        rr_model = 2;

        // Framing error on src3, then clear, then clear coinciding with a new error.
        clear_srcs();
        sbeats[3][0] = mk_beat(3, 1'b0, 1);
        sbeats[3][1] = mk_beat(3, 1'b1, 1);
        sbeats[3][2] = mk_beat(3, 1'b0, 1);
        sbeats[3][3] = mk_beat(3, 1'b1, 1);
        scount[3] = 2;
        drive_src();
        step();
        check("B grant_id", grant_id, 3);
        step();
        check("B err_before", block_err, 0);
        sptr[3]++;
        drive_src();
        step();
        check("B err_set", block_err, 1);
        check("B forwarded", cur_out(), sbeats[3][1]);
        sptr[3]++;
        drive_src();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("B err_cleared", block_err, 0);
        scount[3] = 4;
        err_clear = 1'b1;
        drive_src();
        step();
        step();
        sptr[3]++;
        drive_src();
        step();
        check("B set_wins", block_err, 1);
        sptr[3]++;
        err_clear = 1'b0;
        drive_src();
        step();
        check("B sticky", block_err, 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        rr_model = 0;

        // Reset during the second of four beats.
        clear_srcs();
        for (int k = 0; k < 4; k++) sbeats[0][k] = mk_beat(0, k == 3, 3 - k);
        scount[0] = 4;
        drive_src();
        step();
        step();
        sptr[0]++;
        drive_src();
        @(negedge hclk);
        hreset = 1'b1;
        #1;
        check("C rst valid", packet_data_valid, 0);
        check("C rst grant", grant_active, 0);
        check("C rst ready", src_ready, 0);
        clear_srcs();
        drive_src();
        @(negedge hclk);
        hreset = 1'b0;
        rr_model = 0;
        sbeats[1][0] = mk_beat(1, 1'b1, 0);
        sbeats[3][0] = mk_beat(3, 1'b1, 0);
        scount[1] = 1;
        scount[3] = 1;
        drive_src();
        step();
        check("C regrant_id", grant_id, 1);
        run_loop(0, 1'b0, "C");

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
